// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 encryption core:
//   NR           - number of AES-128 rounds
//   aes_state_e  - FSM state encoding (IDLE, RUN, DONE)
//   rcon_of      - round constant for rounds 1..10
//   xtime/gf_mul - GF(2^8) arithmetic helpers
//   sbox         - AES S-box (multiplicative inverse + affine transform)
//   sub_byte, shift_row, mix_col - 128-bit state transforms, column-major,
//                  byte 0 in bits [127:120]
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int NR = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } aes_state_e;

   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Inverse computed as x^254 (x^2 * x^4 * ... * x^128); 0 maps to 0.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_byte(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   // Row r of column c takes the byte from column (c+r) mod 4.
   function automatic logic [127:0] shift_row(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_col(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_round_unit.sv
// -----------------------------------------------------------------------------
// aes_round_unit
// One combinational AES round plus the matching on-the-fly key step.
// Ports:
//   i_state [127:0] - state entering the round
//   i_rkey  [127:0] - previous round key
//   i_rcon  [7:0]   - round constant for this round
//   i_last          - final round: MixColumns is bypassed
//   o_state [127:0] - state after AddRoundKey with the new key
//   o_rkey  [127:0] - new round key
// -----------------------------------------------------------------------------
module aes_round_unit
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_rkey,
   input  logic [7:0]   i_rcon,
   input  logic         i_last,
   output logic [127:0] o_state,
   output logic [127:0] o_rkey
);

   logic [31:0]  w_rot;
   logic [31:0]  w_sub;
   logic [31:0]  w_k0, w_k1, w_k2, w_k3;
   logic [127:0] w_sr;
   logic [127:0] w_mc;

   // Key expansion: SubWord(RotWord(w3)) feeds the first word, then a prefix XOR chain.
   always_comb begin
      w_rot = {i_rkey[23:0], i_rkey[31:24]};
      w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
      w_k0  = i_rkey[127:96] ^ w_sub ^ {i_rcon, 24'h000000};
      w_k1  = i_rkey[95:64] ^ w_k0;
      w_k2  = i_rkey[63:32] ^ w_k1;
      w_k3  = i_rkey[31:0] ^ w_k2;
      o_rkey = {w_k0, w_k1, w_k2, w_k3};
   end

   // Round transform; the last round omits MixColumns.
   always_comb begin
      w_sr = shift_row(sub_byte(i_state));
      if (i_last) begin
         w_mc = w_sr;
      end else begin
         w_mc = mix_col(w_sr);
      end
      o_state = w_mc ^ o_rkey;
   end

endmodule

// File: rtl/aes_iter_core.sv
// -----------------------------------------------------------------------------
// aes_iter_core
// Iterative AES-128 encryptor, UNROLL rounds per clock (1, 2, 5 or 10), one
// block in flight, round keys expanded on the fly.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   - plaintext/key handshake (in_ready high only in IDLE)
//   data_in, key_in     - 128-bit plaintext and key, byte 0 in [127:120]
//   out_valid/out_ready - ciphertext handshake (out_valid high only in DONE)
//   data_out            - registered ciphertext
// Build option AES_ZEROIZE_EN: when defined, state, round key and data_out
// are cleared on the output handshake so no ciphertext or key material lingers.
// -----------------------------------------------------------------------------
module aes_iter_core
   import aes_pkg::*;
#(
   parameter int UNROLL = 1
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
      $error("aes_iter_core: UNROLL must be 1, 2, 5 or 10");
   end

   aes_state_e   r_fsm;
   logic [127:0] r_state;
   logic [127:0] r_rkey;
   logic [3:0]   r_rnd;
   logic [127:0] r_data_out;
   logic         r_in_ready;
   logic         r_out_valid;

   logic [127:0] w_next_state;
   logic [127:0] w_next_rkey;
   logic         w_last;

   // Chain of round units; stage k computes round r_rnd + k.
   for (genvar k = 0; k < UNROLL; k++) begin : g_round
      logic [127:0] w_st_i, w_key_i, w_st_o, w_key_o;
      logic [3:0]   w_rnd;
      assign w_rnd = r_rnd + 4'(k);
      if (k == 0) begin : g_head
         assign w_st_i  = r_state;
         assign w_key_i = r_rkey;
      end else begin : g_link
         assign w_st_i  = g_round[k-1].w_st_o;
         assign w_key_i = g_round[k-1].w_key_o;
      end
      aes_round_unit u_round (
         .i_state (w_st_i),
         .i_rkey  (w_key_i),
         .i_rcon  (rcon_of(w_rnd)),
         .i_last  (w_rnd == 4'(NR)),
         .o_state (w_st_o),
         .o_rkey  (w_key_o)
      );
   end

   assign w_next_state = g_round[UNROLL-1].w_st_o;
   assign w_next_rkey  = g_round[UNROLL-1].w_key_o;
   // UNROLL divides NR, so the final round always lands on the last stage.
   assign w_last       = (g_round[UNROLL-1].w_rnd == 4'(NR));

   // Control FSM with registered handshake flags and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm       <= ST_IDLE;
         r_state     <= 128'h0;
         r_rkey      <= 128'h0;
         r_rnd       <= 4'd0;
         r_data_out  <= 128'h0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               if (in_valid) begin
                  r_state    <= data_in ^ key_in;
                  r_rkey     <= key_in;
                  r_rnd      <= 4'd1;
                  r_in_ready <= 1'b0;
                  r_fsm      <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_state <= w_next_state;
               r_rkey  <= w_next_rkey;
               r_rnd   <= r_rnd + 4'(UNROLL);
               if (w_last) begin
                  r_data_out  <= w_next_state;
                  r_out_valid <= 1'b1;
                  r_fsm       <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_fsm       <= ST_IDLE;
`ifdef AES_ZEROIZE_EN
                  r_state     <= 128'h0;
                  r_rkey      <= 128'h0;
                  r_data_out  <= 128'h0;
`endif
               end
            end
            default: begin
               r_fsm       <= ST_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign data_out  = r_data_out;

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench: four cores (UNROLL 1, 2, 5, 10) sharing data/key inputs,
// directed FIPS-197 vectors plus random vectors against a table-based model.
module tb_aes_iter_core;

   localparam int UNR [4] = '{1, 2, 5, 10};

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   localparam logic [127:0] SB [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic         clk;
   logic         rst_n;
   logic [127:0] data_in;
   logic [127:0] key_in;
   logic         in_valid  [4];
   logic         in_ready  [4];
   logic         out_valid [4];
   logic         out_ready [4];
   logic [127:0] data_out  [4];

   int errors = 0;
   int checks = 0;
   int cyc_cnt = 0;
   logic [127:0] exp_q [$];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      aes_iter_core #(.UNROLL(UNR[g])) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .data_in   (data_in),
         .key_in    (key_in),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .data_out  (data_out[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [127:0] row;
      row = SB[x[7:4]];
      return row[127-8*x[3:0] -: 8];
   endfunction

   function automatic logic [7:0] mul2(input logic [7:0] x);
      return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] ct;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
            rc  = mul2(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
               s[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      return ct;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input int idx, input logic [127:0] k, input logic [127:0] p,
                       output int acc_cyc);
      int n;
      key_in = k;
      data_in = p;
      in_valid[idx] = 1'b1;
      n = 0;
      while (!in_ready[idx] && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk("in_ready_timeout", 128'(in_ready[idx]), 128'd1);
      @(posedge clk); #1;
      acc_cyc = cyc_cnt;
      in_valid[idx] = 1'b0;
   endtask

   task automatic wait_out(input int idx, output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid[idx] && lat < 60);
   endtask

   task automatic check_ct(input string tag, input int idx);
      logic [127:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 128'(exp_q.size()), 128'd1);
      end else begin
         e = exp_q.pop_front();
         chk(tag, data_out[idx], e);
      end
   endtask

   task automatic handshake(input int idx);
      out_ready[idx] = 1'b1;
      @(posedge clk); #1;
      out_ready[idx] = 1'b0;
      chk("hs_out_valid_low", 128'(out_valid[idx]), 128'd0);
      chk("hs_in_ready_high", 128'(in_ready[idx]), 128'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      int acc;
      int acc_t [3];
      logic [127:0] ct1;
      logic [127:0] rk, rp;

      rst_n = 1'b0;
      data_in = 128'h0;
      key_in = 128'h0;
      for (int i = 0; i < 4; i++) begin
         in_valid[i] = 1'b0;
         out_ready[i] = 1'b0;
      end
      #22;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset_in_ready_%0d", i), 128'(in_ready[i]), 128'd1);
         chk($sformatf("reset_out_valid_%0d", i), 128'(out_valid[i]), 128'd0);
         chk($sformatf("reset_data_out_%0d", i), data_out[i], 128'h0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 C.1, UNROLL=1
      exp_q.push_back(C1_CT);
      send(0, C1_KEY, C1_PT, acc);
      chk("c1_in_ready_low", 128'(in_ready[0]), 128'd0);
      chk("c1_no_early_valid", 128'(out_valid[0]), 128'd0);
      wait_out(0, lat);
      chk("c1_latency", 128'(lat), 128'd10);
      check_ct("c1_ct", 0);
      handshake(0);
`ifdef AES_ZEROIZE_EN
      chk("zeroize_after_hs", data_out[0], 128'h0);
`else
      chk("retain_after_hs", data_out[0], C1_CT);
`endif

      // FIPS-197 App. B on UNROLL 2, 5, 10
      for (int d = 1; d < 4; d++) begin
         exp_q.push_back(B_CT);
         send(d, B_KEY, B_PT, acc);
         wait_out(d, lat);
         chk($sformatf("appb_latency_u%0d", UNR[d]), 128'(lat), 128'(10 / UNR[d]));
         check_ct($sformatf("appb_ct_u%0d", UNR[d]), d);
         handshake(d);
      end

      // Backpressure: hold out_ready low while a second block waits
      exp_q.push_back(C1_CT);
      send(0, C1_KEY, C1_PT, acc);
      wait_out(0, lat);
      chk("bp_latency", 128'(lat), 128'd10);
      ct1 = data_out[0];
      check_ct("bp_ct1", 0);
      key_in = B_KEY;
      data_in = B_PT;
      in_valid[0] = 1'b1;
      exp_q.push_back(B_CT);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("bp_data_stable", data_out[0], ct1);
         chk("bp_in_ready_low", 128'(in_ready[0]), 128'd0);
         chk("bp_out_valid_held", 128'(out_valid[0]), 128'd1);
      end
      handshake(0);
      send(0, B_KEY, B_PT, acc);
      chk("bp_second_accepted", 128'(in_ready[0]), 128'd0);
      wait_out(0, lat);
      chk("bp2_latency", 128'(lat), 128'd10);
      check_ct("bp2_ct", 0);
      handshake(0);

      // Reset during RUN
      send(0, C1_KEY, C1_PT, acc);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
      chk("rst_data_out", data_out[0], 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst_in_ready", 128'(in_ready[0]), 128'd1);
      exp_q.push_back(C1_CT);
      send(0, C1_KEY, C1_PT, acc);
      wait_out(0, lat);
      chk("rst_c1_latency", 128'(lat), 128'd10);
      check_ct("rst_c1_ct", 0);
      handshake(0);

      // Back-to-back random vectors with out_ready held high
      out_ready[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rk = {$urandom(), $urandom(), $urandom(), $urandom()};
         rp = {$urandom(), $urandom(), $urandom(), $urandom()};
         exp_q.push_back(aes_ref(rk, rp));
         send(0, rk, rp, acc_t[i]);
         wait_out(0, lat);
         chk($sformatf("b2b_latency_%0d", i), 128'(lat), 128'd10);
         check_ct($sformatf("b2b_ct_%0d", i), 0);
      end
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      chk("b2b_interval_01", 128'(acc_t[1] - acc_t[0]), 128'd12);
      chk("b2b_interval_12", 128'(acc_t[2] - acc_t[1]), 128'd12);
      chk("b2b_idle_after", 128'(in_ready[0]), 128'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
